// File: rtl/spi_reg_pkg.sv
// Shared types, command field positions and SPI mode decode for the
// SPI register-burst bridge.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        LOAD,
        DATA
    } state_e;

    // Command field positions, counted down from the command word MSB.
    localparam int unsigned CMD_RW_OFS = 1;
    localparam int unsigned CMD_TW_OFS = 3;

    function automatic logic sample_on_rising(input logic cpol, input logic cpha);
        return ~(cpol ^ cpha);
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchroniser for an asynchronous SPI pin, with a one-clk pulse on
// either transition; the synchronised level gives the transition direction.
module spi_edge_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstb,
    input  logic din,
    output logic level,
    output logic toggle
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level  = sync_q;
    assign toggle = sync_q ^ prev_q;

endmodule

// File: rtl/spi_reg_burst.sv
// SPI slave to register-bus bridge: one command word per frame, then single
// or burst word reads/writes while spi_cs_n stays low.
module spi_reg_burst
    import spi_reg_pkg::*;
#(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned REG_W    = 32,
    parameter int unsigned CMD_W    = 8,
    parameter int unsigned AUTO_INC = 1
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              spi_clk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_rw,
    output logic [1:0]        txn_width,
    output logic              reg_addr_v,
    input  logic [REG_W-1:0]  reg_data_i,
    output logic [REG_W-1:0]  reg_data_o,
    output logic              reg_data_o_dv,
    output logic [7:0]        burst_cnt
);

    localparam int unsigned SH_W  = (REG_W > CMD_W) ? REG_W : CMD_W;
    localparam int unsigned CNT_W = $clog2(SH_W + 1);
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] REG_LAST = CNT_W'(REG_W - 1);

    logic clk_lvl, clk_evt;
    logic cs_lvl, cs_evt;
    logic mosi_meta_q, mosi_q;

    spi_edge_sync #(.RST_VAL(1'b0)) u_clk_sync (
        .clk    (clk),
        .rstb   (rstb),
        .din    (spi_clk),
        .level  (clk_lvl),
        .toggle (clk_evt)
    );

    spi_edge_sync #(.RST_VAL(1'b1)) u_cs_sync (
        .clk    (clk),
        .rstb   (rstb),
        .din    (spi_cs_n),
        .level  (cs_lvl),
        .toggle (cs_evt)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            mosi_meta_q <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            mosi_meta_q <= spi_mosi;
            mosi_q      <= mosi_meta_q;
        end
    end

    // CS counts as low in the cycle its rising edge appears, so a word whose
    // final sample coincides with CS release still completes.
    logic cs_active, cs_fall, smp_rise, sample_edge, change_edge;
    assign cs_active   = ~cs_lvl | cs_evt;
    assign cs_fall     = cs_evt & ~cs_lvl;
    assign smp_rise    = sample_on_rising(cpol, cpha);
    assign sample_edge = cs_active & clk_evt & (clk_lvl == smp_rise);
    assign change_edge = cs_active & clk_evt & (clk_lvl != smp_rise);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [SH_W-1:0]   shift_q, shift_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [1:0]        txn_q, txn_d;
    logic [REG_W-1:0]  data_o_q, data_o_d;
    logic              dv_q, dv_d;
    logic              inc_pend_q, inc_pend_d;
    logic [7:0]        burst_q, burst_d;

    logic [SH_W-1:0]  shift_in;
    logic [CMD_W-1:0] cmd;
    logic [7:0]       burst_inc;
    assign shift_in  = {shift_q[SH_W-2:0], mosi_q};
    assign cmd       = shift_in[CMD_W-1:0];
    assign burst_inc = (burst_q == 8'hFF) ? burst_q : burst_q + 8'd1;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            txn_q      <= 2'b11;
            data_o_q   <= '0;
            dv_q       <= 1'b0;
            inc_pend_q <= 1'b0;
            burst_q    <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            txn_q      <= txn_d;
            data_o_q   <= data_o_d;
            dv_q       <= dv_d;
            inc_pend_q <= inc_pend_d;
            burst_q    <= burst_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        txn_d      = txn_q;
        data_o_d   = data_o_q;
        dv_d       = 1'b0;
        inc_pend_d = inc_pend_q;
        burst_d    = burst_q;
        if (ena) begin
            // Write bursts advance the address one cycle after the strobe.
            if (inc_pend_q) begin
                inc_pend_d = 1'b0;
                if (AUTO_INC != 0) addr_d = addr_q + ADDR_W'(1);
            end
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d   = CMD;
                        bit_cnt_d = '0;
                        burst_d   = '0;
                    end
                end
                CMD: begin
                    if (sample_edge) begin
                        shift_d = shift_in;
                        if (bit_cnt_q == CMD_LAST) begin
                            bit_cnt_d = '0;
                            rw_d      = cmd[CMD_W-CMD_RW_OFS];
                            txn_d     = cmd[CMD_W-CMD_TW_OFS +: 2];
                            addr_d    = cmd[ADDR_W-1:0];
                            state_d   = cmd[CMD_W-CMD_RW_OFS] ? DATA : LOAD;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                LOAD: begin
                    shift_d = SH_W'(reg_data_i);
                    state_d = DATA;
                end
                DATA: begin
                    if (rw_q) begin
                        if (sample_edge) begin
                            shift_d = shift_in;
                            if (bit_cnt_q == REG_LAST) begin
                                bit_cnt_d  = '0;
                                data_o_d   = shift_in[REG_W-1:0];
                                dv_d       = 1'b1;
                                inc_pend_d = 1'b1;
                                burst_d    = burst_inc;
                            end else begin
                                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end else if (sample_edge) begin
                        if (bit_cnt_q == REG_LAST) begin
                            bit_cnt_d = '0;
                            burst_d   = burst_inc;
                            state_d   = LOAD;
                            if (AUTO_INC != 0) addr_d = addr_q + ADDR_W'(1);
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end else if (change_edge && bit_cnt_q != '0) begin
                        shift_d = shift_q << 1;
                    end
                end
                default: state_d = IDLE;
            endcase
            // CS level rather than its edge, so a release missed while ena was
            // low still ends the frame.
            if (state_q != IDLE && cs_lvl) state_d = IDLE;
        end
    end

    always_comb begin
        spi_miso = 1'b0;
        if (state_q == LOAD) begin
            spi_miso = reg_data_i[REG_W-1];
        end else if (state_q == DATA && !rw_q) begin
            spi_miso = shift_q[REG_W-1];
        end
    end

    assign reg_addr      = addr_q;
    assign reg_rw        = rw_q;
    assign txn_width     = txn_q;
    assign reg_addr_v    = ena & (state_q == LOAD);
    assign reg_data_o    = data_o_q;
    assign reg_data_o_dv = dv_q;
    assign burst_cnt     = burst_q;

endmodule

// File: doc/spi_reg_burst.md
Name: spi_reg_burst

Overview:
- Parametrised SPI slave register-access bridge: converts SPI frames into single or burst register reads and writes on a simple strobe bus toward the peripheral register file.
- Runtime-selectable SPI mode (0-3), configurable command/data/address widths, optional address auto-increment for multi-word bursts while spi_cs_n stays low.
- Sits between the test-harness SPI pins and the peripheral register bus; fully synchronous to clk.

Parameters:
- ADDR_W, 5, address field width; must be <= CMD_W-3.
- REG_W, 32, data word width in bits (8..63).
- CMD_W, 8, command word width in bits.
- AUTO_INC, 1, 1: address increments after every data word in a burst; 0: address fixed for the whole frame.

Ports:
- clk  in  1  system clock.
- rstb  in  1  reset; asynchronous, active-low.
- ena  in  1  clock enable; when low, all state and outputs hold.
- cpol  in  1  SPI clock idle level; static while spi_cs_n low.
- cpha  in  1  SPI clock phase; static while spi_cs_n low.
- spi_clk  in  1  SPI clock (asynchronous).
- spi_cs_n  in  1  SPI chip select, active-low (asynchronous).
- spi_mosi  in  1  SPI data in (asynchronous).
- spi_miso  out  1  SPI data out.
- reg_addr  out  ADDR_W  current word address.
- reg_rw  out  1  1 = write frame, 0 = read frame.
- txn_width  out  2  transaction width field from the command.
- reg_addr_v  out  1  one-clk read strobe; reg_data_i sampled in this same cycle.
- reg_data_i  in  REG_W  read data (combinational from reg_addr).
- reg_data_o  out  REG_W  write data.
- reg_data_o_dv  out  1  one-clk write strobe; reg_addr/reg_data_o valid this cycle.
- burst_cnt  out  8  words completed in current frame; saturates at 255.

Behaviour:
- Reset values: spi_miso 0, reg_addr 0, reg_rw 0, txn_width 2'b11, reg_addr_v 0, reg_data_o 0, reg_data_o_dv 0, burst_cnt 0; state IDLE.
- spi_clk, spi_cs_n, spi_mosi pass through 2-flop synchronisers; edges are detected on the synchronised signals. Requirement: each spi_clk half-period >= 4 clk cycles.
- Sample edge: rising if cpol^cpha == 0, else falling. Change edge is the opposite edge. Edges count only while synchronised spi_cs_n is low.
- Command word, MSB first: bit CMD_W-1 = rw; bits CMD_W-2:CMD_W-3 = txn_width; bits ADDR_W-1:0 = address; remaining bits ignored.
- States:
  - IDLE: wait for CS falling edge -> CMD. bit_cnt and burst_cnt clear.
  - CMD: shift mosi on sample edges. After the CMD_W-th sample, latch rw, txn_width, addr; go to LOAD if rw = 0, else DATA.
  - LOAD: single clk. reg_addr_v = 1; shift register <= reg_data_i; go to DATA.
  - DATA, write: shift REG_W bits. After the REG_W-th sample, reg_data_o <= word and reg_data_o_dv pulses the next clk with the pre-increment reg_addr. addr advances next cycle (if AUTO_INC); burst_cnt++; stay in DATA.
  - DATA, read: miso = shift register MSB. Shift left on a change edge only when bit_cnt != 0; this rule is uniform across all modes and keeps the loaded MSB through the first edge. After the REG_W-th sample: addr advances (if AUTO_INC), burst_cnt++, then LOAD for the next word.
- Address wraps modulo 2^ADDR_W (e.g. 31 -> 0 for ADDR_W = 5).
- spi_miso is 0 in every state except read DATA/LOAD.
- CS rising edge in any state -> IDLE next clk. A partial word is discarded: no strobe, no address change. reg_addr, reg_rw, and txn_width keep their last values.
- CS rising edge in the same clk as a word-completing sample: the word completes and strobes first, then IDLE.
- CS low for an incomplete CMD word, then high: no bus activity.
- ena low: nothing advances; strobes do not fire. Pending edges seen while ena is low are lost.
- rstb asserted mid-frame: immediate return to reset values. The bench re-frames after release.

Decomposition:
- Shared package spi_reg_pkg: state enum (IDLE, CMD, LOAD, DATA), command field position constants, mode decode function (sample_on_rising = ~(cpol^cpha)).
- One sub-module: spi_edge_sync (2-flop synchroniser plus rise/fall pulse), instantiated for spi_clk and spi_cs_n. mosi uses the synchroniser only.

Test Plan:
- Mode 0 single write: cmd 0x83, data 0xDEADBEEF -> one reg_data_o_dv with reg_addr = 3, reg_data_o = 0xDEADBEEF, txn_width = 2'b00, burst_cnt = 1.
- Mode 3 burst read, AUTO_INC = 1: cmd 0x1E, 3 words; reg_data_i = {addr, 27'h0} -> reg_addr_v at addr 30, 31, 0. miso returns 0xF0000000, 0xF8000000, 0x00000000.
- Modes 1 and 2 write: same frame as the first scenario -> identical bus result. Mismatched edge selection must fail.
- Abort: CS high after 20 data bits of a write at addr 5 -> no dv, reg_addr stays 5, next frame works normally.
- AUTO_INC = 0 burst write of 2 words to addr 7 -> two dv pulses, both reg_addr = 7.
- ena held low for 50 clks mid-frame (SPI clock paused) -> frame resumes, correct single dv. Asserting rstb mid-read -> all outputs at reset values within one clk.
